mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-access stage sitting directly upstream of the 256×8 data memory. It accepts load, store and block-fill requests from the execute stage over a valid/ready handshake and drives the memory's address, active-low write enable and write data. Load results are registered and returned to writeback over a second valid/ready handshake. Block fills are sequenced internally, one byte per cycle.

## Interface
- ADDR_W, 8, memory address width (256 bytes)
- DATA_W, 8, data width
- RD_W, 3, destination-register tag width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_op  in  2  00 LOAD, 01 STORE, 10 FILL, 11 NOP
- req_addr  in  ADDR_W  byte address / FILL base address
- req_data  in  DATA_W  STORE data / FILL pattern
- req_len  in  ADDR_W  FILL byte count (0 = no write)
- req_rd  in  RD_W  LOAD destination tag
- mem_addr  out  ADDR_W  to data memory address
- mem_we_n  out  1  to data memory write enable; 0 = write on rising edge
- mem_wdata  out  DATA_W  to data memory write data
- mem_rdata  in  DATA_W  combinational read data from memory at mem_addr
- wb_valid  out  1  load result valid
- wb_ready  in  1  writeback consumes result
- wb_rd  out  RD_W  tag of returned load
- wb_data  out  DATA_W  loaded byte
- busy  out  1  FILL in progress

## Operation
- States: IDLE, FILL.
- req_ready = !rst && state==IDLE && (!wb_valid || wb_ready). accept = req_valid && req_ready.
- LOAD (accept): mem_addr=req_addr, mem_we_n=1; at the edge, wb_data<=mem_rdata, wb_rd<=req_rd, wb_valid<=1.
- STORE (accept): mem_addr=req_addr, mem_wdata=req_data, mem_we_n=0 for that cycle only; no writeback.
- FILL (accept, req_len≠0): latch cur_addr=req_addr, pattern=req_data, remaining=req_len; go to FILL. req_len=0: accepted, no write, stay IDLE.
- NOP: accepted, no memory or writeback effect.
- FILL state: mem_addr=cur_addr, mem_wdata=pattern, mem_we_n=0; each cycle cur_addr+=1 (mod 256, 0xFF wraps to 0x00), remaining-=1; remaining==1 in a FILL cycle → last write, return to IDLE next cycle. busy=1 throughout FILL; req_ready=0.
- Idle with no accept: mem_we_n=1, mem_addr=req_addr, mem_wdata=req_data.
- wb_valid: cleared when wb_valid && wb_ready and no LOAD accepted that cycle; if a LOAD is accepted in the same cycle the result is consumed, the new result replaces it and wb_valid stays 1.
- A stalled result (wb_valid && !wb_ready) holds wb_rd/wb_data stable and blocks all requests, including stores.

## Timing
- Reset (async, immediate): state=IDLE, wb_valid=0, wb_data=0, wb_rd=0, cur_addr=0, remaining=0, busy=0; mem_we_n=1 and req_ready=0 while rst is high.
- Reset mid-FILL: fill aborts at once; bytes already written stay written; no further writes.
- LOAD latency: 1 cycle, accept edge → wb_valid high.
- STORE: memory updated at the accept edge; a LOAD of the same address accepted the next cycle returns the new byte.
- FILL of N bytes (1..255): accept cycle, then exactly N write cycles, req_ready high again in cycle N+1 after accept. Throughput: one request per cycle for LOAD/STORE/NOP when writeback is not stalled.
- mem_we_n never low in a cycle without accept of STORE or state FILL.

## Test plan
- Reset with rst raised mid-cycle → wb_valid=0, busy=0, mem_we_n=1, req_ready=0 immediately; req_ready=1 first cycle after release.
- STORE 0x5A @0x10, then LOAD @0x10 tag 3 → wb_valid next cycle, wb_rd=3, wb_data=0x5A.
- FILL base 0xFE, len 4, data 0xC3 → writes at 0xFE,0xFF,0x00,0x01 on 4 consecutive cycles, busy=1 for 4 cycles, req_ready low throughout; loads then return 0xC3, 0x02 unchanged.
- Back-to-back LOADs @0x00,@0x01 with wb_ready=1 → wb_valid stays high, results appear on consecutive cycles in order.
- LOAD with wb_ready=0 for 3 cycles → wb_data/wb_rd stable, req_ready=0, a pending STORE issues no write (mem_we_n=1) until wb_ready=1.
- FILL len 0 and NOP → accepted in one cycle, mem_we_n stays 1, busy stays 0; rst asserted in 2nd cycle of a len-8 FILL → only first byte written.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-access stage in front of the 256x8 data memory: issues loads and
// stores from execute, sequences block fills, and returns load results to writeback.
module mem_access_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [ADDR_W-1:0] req_len,
  input  logic [RD_W-1:0]   req_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we_n,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] remaining;
  logic [DATA_W-1:0] pattern;
  logic              accept;

  // A stalled writeback result blocks every request, stores included.
  assign req_ready = !rst && (state == IDLE) && (!wb_valid || wb_ready);
  assign accept    = req_valid && req_ready;
  assign busy      = (state == FILL);

  always_comb begin
    mem_addr  = req_addr;
    mem_wdata = req_data;
    mem_we_n  = 1'b1;
    if (state == FILL) begin
      mem_addr  = cur_addr;
      mem_wdata = pattern;
      mem_we_n  = 1'b0;
    end else if (accept && (req_op == OP_STORE)) begin
      mem_we_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      pattern   <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      // A load accepted alongside a consumed result replaces it without a bubble.
      if (accept && (req_op == OP_LOAD)) begin
        wb_valid <= 1'b1;
        wb_rd    <= req_rd;
        wb_data  <= mem_rdata;
      end else if (wb_valid && wb_ready) begin
        wb_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept && (req_op == OP_FILL) && (req_len != '0)) begin
            cur_addr  <= req_addr;
            pattern   <= req_data;
            remaining <= req_len;
            state     <= FILL;
          end
        end
        FILL: begin
          cur_addr  <= cur_addr + 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == 1) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 256x8 memory;
// inputs change just after the rising edge, outputs are checked on the falling edge.
module tb_mem_access_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr;
  logic [7:0] req_data;
  logic [7:0] req_len;
  logic [2:0] req_rd;
  logic [7:0] mem_addr;
  logic       mem_we_n;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       wb_valid;
  logic       wb_ready;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       busy;

  logic [7:0] mem [256];
  logic       mem_clear;
  int         tests_run = 0;
  int         tests_failed = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .req_len(req_len), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_we_n(mem_we_n), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy)
  );

  // Memory preloads mem[i] = i so untouched bytes are recognisable.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= i[7:0];
    end else if (!mem_we_n) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] len, input logic [2:0] rd);
    req_valid = v; req_op = op; req_addr = a; req_data = d; req_len = len; req_rd = rd;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_release_ready: got %b want 1", req_ready); end
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_wb_valid: got %b want 0", wb_valid); end
    step();
    wb_ready = 1'b0;
    drive(1'b1, 2'b00, 8'h05, 8'h00, 8'h00, 3'd2);
    step();
    drive(1'b1, 2'b01, 8'h06, 8'hAA, 8'h00, 3'd0);
    #3;
    rst = 1'b1;
    #1;
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_wb_valid: got %b want 0", wb_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_busy: got %b want 0", busy); end
    tests_run++; if (mem_we_n !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_mid_we_n: got %b want 1", mem_we_n); end
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_ready: got %b want 0", req_ready); end
    tests_run++; if ({wb_rd, wb_data} !== 11'd0) begin tests_failed++; $display("[TB] FAIL rst_mid_wb_regs: got rd %0d data %h want 0/00", wb_rd, wb_data); end
    drive(1'b0, 2'b11, 8'h00, 8'h00, 8'h00, 3'd0);
    wb_ready = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_rerelease_ready: got %b want 1", req_ready); end
    tests_run++; if (mem[8'h06] !== 8'h06) begin tests_failed++; $display("[TB] FAIL rst_no_store: got %h want 06", mem[8'h06]); end
    step();
  endtask

  task automatic test_store_load();
    drive(1'b1, 2'b01, 8'h10, 8'h5A, 8'h00, 3'd0);
    @(negedge clk);
    tests_run++; if ({mem_we_n, mem_addr, mem_wdata} !== {1'b0, 8'h10, 8'h5A}) begin tests_failed++; $display("[TB] FAIL store_drive: got we_n %b addr %h data %h want 0/10/5a", mem_we_n, mem_addr, mem_wdata); end
    step();
    drive(1'b1, 2'b00, 8'h10, 8'h00, 8'h00, 3'd3);
    @(negedge clk);
    tests_run++; if (mem_we_n !== 1'b1) begin tests_failed++; $display("[TB] FAIL load_we_n: got %b want 1", mem_we_n); end
    step();
    drive(1'b0, 2'b11, 8'h00, 8'h00, 8'h00, 3'd0);
    @(negedge clk);
    tests_run++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 3'd3, 8'h5A}) begin tests_failed++; $display("[TB] FAIL load_result: got v %b rd %0d data %h want 1/3/5a", wb_valid, wb_rd, wb_data); end
    step();
    @(negedge clk);
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL load_consumed: got %b want 0", wb_valid); end
    step();
  endtask

  task automatic test_fill_wrap();
    logic [7:0] exp_addr;
    drive(1'b1, 2'b10, 8'hFE, 8'hC3, 8'd4, 3'd0);
    @(negedge clk);
    tests_run++; if ({req_ready, mem_we_n, busy} !== 3'b110) begin tests_failed++; $display("[TB] FAIL fill_accept: got ready %b we_n %b busy %b want 1/1/0", req_ready, mem_we_n, busy); end
    step();
    drive(1'b0, 2'b11, 8'h00, 8'h00, 8'h00, 3'd0);
    for (int k = 0; k < 4; k++) begin
      exp_addr = 8'hFE + k[7:0];
      @(negedge clk);
      tests_run++; if ({busy, req_ready, mem_we_n, mem_addr, mem_wdata} !== {3'b100, exp_addr, 8'hC3}) begin tests_failed++; $display("[TB] FAIL fill_cycle%0d: got busy %b ready %b we_n %b addr %h data %h want 1/0/0/%h/c3", k, busy, req_ready, mem_we_n, mem_addr, mem_wdata, exp_addr); end
      step();
    end
    @(negedge clk);
    tests_run++; if ({busy, req_ready, mem_we_n} !== 3'b011) begin tests_failed++; $display("[TB] FAIL fill_done: got busy %b ready %b we_n %b want 0/1/1", busy, req_ready, mem_we_n); end
    tests_run++; if ({mem[8'hFD], mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01], mem[8'h02]} !== 48'hFD_C3C3_C3C3_02) begin tests_failed++; $display("[TB] FAIL fill_memory: got %h %h %h %h %h %h want fd c3 c3 c3 c3 02", mem[8'hFD], mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01], mem[8'h02]); end
    drive(1'b1, 2'b00, 8'hFE, 8'h00, 8'h00, 3'd5);
    step();
    drive(1'b1, 2'b00, 8'h02, 8'h00, 8'h00, 3'd6);
    @(negedge clk);
    tests_run++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 3'd5, 8'hC3}) begin tests_failed++; $display("[TB] FAIL fill_load_fe: got v %b rd %0d data %h want 1/5/c3", wb_valid, wb_rd, wb_data); end
    step();
    drive(1'b0, 2'b11, 8'h00, 8'h00, 8'h00, 3'd0);
    @(negedge clk);
    tests_run++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 3'd6, 8'h02}) begin tests_failed++; $display("[TB] FAIL fill_load_02: got v %b rd %0d data %h want 1/6/02", wb_valid, wb_rd, wb_data); end
    step();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b01, 8'h01, 8'h11, 8'h00, 3'd0);
    step();
    drive(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 3'd1);
    step();
    drive(1'b1, 2'b00, 8'h01, 8'h00, 8'h00, 3'd2);
    @(negedge clk);
    tests_run++; if ({wb_valid, wb_rd, wb_data, req_ready} !== {1'b1, 3'd1, 8'hC3, 1'b1}) begin tests_failed++; $display("[TB] FAIL b2b_first: got v %b rd %0d data %h ready %b want 1/1/c3/1", wb_valid, wb_rd, wb_data, req_ready); end
    step();
    drive(1'b1, 2'b00, 8'h20, 8'h00, 8'h00, 3'd7);
    @(negedge clk);
    tests_run++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 3'd2, 8'h11}) begin tests_failed++; $display("[TB] FAIL b2b_second: got v %b rd %0d data %h want 1/2/11", wb_valid, wb_rd, wb_data); end
    step();
    drive(1'b0, 2'b11, 8'h00, 8'h00, 8'h00, 3'd0);
    @(negedge clk);
    tests_run++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 3'd7, 8'h20}) begin tests_failed++; $display("[TB] FAIL b2b_third: got v %b rd %0d data %h want 1/7/20", wb_valid, wb_rd, wb_data); end
    step();
    @(negedge clk);
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_drain: got %b want 0", wb_valid); end
    step();
  endtask

  task automatic test_stall();
    wb_ready = 1'b0;
    drive(1'b1, 2'b00, 8'h10, 8'h00, 8'h00, 3'd3);
    step();
    drive(1'b1, 2'b01, 8'h30, 8'h77, 8'h00, 3'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++; if ({wb_valid, wb_rd, wb_data, req_ready, mem_we_n} !== {1'b1, 3'd3, 8'h5A, 2'b01}) begin tests_failed++; $display("[TB] FAIL stall_cycle%0d: got v %b rd %0d data %h ready %b we_n %b want 1/3/5a/0/1", k, wb_valid, wb_rd, wb_data, req_ready, mem_we_n); end
      step();
    end
    wb_ready = 1'b1;
    @(negedge clk);
    tests_run++; if ({req_ready, mem_we_n, mem_addr} !== {2'b10, 8'h30}) begin tests_failed++; $display("[TB] FAIL stall_release: got ready %b we_n %b addr %h want 1/0/30", req_ready, mem_we_n, mem_addr); end
    step();
    drive(1'b0, 2'b11, 8'h00, 8'h00, 8'h00, 3'd0);
    @(negedge clk);
    tests_run++; if ({wb_valid, mem[8'h30]} !== {1'b0, 8'h77}) begin tests_failed++; $display("[TB] FAIL stall_after: got v %b mem30 %h want 0/77", wb_valid, mem[8'h30]); end
    step();
  endtask

  task automatic test_fill_zero_nop();
    drive(1'b1, 2'b10, 8'h40, 8'hEE, 8'd0, 3'd0);
    @(negedge clk);
    tests_run++; if ({req_ready, mem_we_n} !== 2'b11) begin tests_failed++; $display("[TB] FAIL fill0_accept: got ready %b we_n %b want 1/1", req_ready, mem_we_n); end
    step();
    drive(1'b1, 2'b11, 8'h41, 8'hEE, 8'd3, 3'd4);
    @(negedge clk);
    tests_run++; if ({req_ready, mem_we_n, busy} !== 3'b110) begin tests_failed++; $display("[TB] FAIL nop_accept: got ready %b we_n %b busy %b want 1/1/0", req_ready, mem_we_n, busy); end
    step();
    drive(1'b0, 2'b11, 8'h00, 8'h00, 8'h00, 3'd0);
    @(negedge clk);
    tests_run++; if ({busy, req_ready, wb_valid, mem_we_n} !== 4'b0101) begin tests_failed++; $display("[TB] FAIL nop_after: got busy %b ready %b v %b we_n %b want 0/1/0/1", busy, req_ready, wb_valid, mem_we_n); end
    tests_run++; if ({mem[8'h40], mem[8'h41]} !== 16'h4041) begin tests_failed++; $display("[TB] FAIL fill0_memory: got %h %h want 40 41", mem[8'h40], mem[8'h41]); end
    step();
  endtask

  task automatic test_reset_mid_fill();
    drive(1'b1, 2'b10, 8'h50, 8'h99, 8'd8, 3'd0);
    step();
    drive(1'b0, 2'b11, 8'h00, 8'h00, 8'h00, 3'd0);
    @(negedge clk);
    tests_run++; if ({mem_we_n, mem_addr} !== {1'b0, 8'h50}) begin tests_failed++; $display("[TB] FAIL rfill_first: got we_n %b addr %h want 0/50", mem_we_n, mem_addr); end
    step();
    #1;
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if ({busy, mem_we_n} !== 2'b01) begin tests_failed++; $display("[TB] FAIL rfill_abort: got busy %b we_n %b want 0/1", busy, mem_we_n); end
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    tests_run++; if ({mem[8'h50], mem[8'h51], mem[8'h57], busy} !== {8'h99, 8'h51, 8'h57, 1'b0}) begin tests_failed++; $display("[TB] FAIL rfill_memory: got %h %h %h busy %b want 99 51 57 0", mem[8'h50], mem[8'h51], mem[8'h57], busy); end
    step();
  endtask

  initial begin
    rst = 1'b1;
    mem_clear = 1'b1;
    wb_ready = 1'b1;
    drive(1'b0, 2'b11, 8'h00, 8'h00, 8'h00, 3'd0);
    step();
    step();
    mem_clear = 1'b0;
    test_reset();
    test_store_load();
    test_fill_wrap();
    test_back_to_back();
    test_stall();
    test_fill_zero_nop();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
